byte_shifter: RTL

BYTE_SHIFTER -- requirements
Module: byte_shifter

---
 rtl/byte_shifter.sv | 136 +++++++++++++
 1 files changed

// File: rtl/byte_shifter.sv
// Frame serialiser: shifts an NBITS word out on sdo/sclk/cs_n, paced by a 500 kHz bit clock.
// Define BYTE_SHIFTER_LSB_FIRST_EN to send bit 0 first; otherwise the MSB goes first.
module byte_shifter #(
    parameter int unsigned NBITS = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk500k,
    input  logic             start,
    input  logic [NBITS-1:0] data,
    output logic             busy,
    output logic             done,
    output logic             cs_n,
    output logic             sclk,
    output logic             sdo
);

    typedef enum logic [1:0] {StIdle, StSetup, StShift, StDone} state_e;

    localparam logic [4:0] LastCnt = 5'(NBITS - 1);

    state_e           state_q, state_d;
    logic [NBITS-1:0] shreg_q, shreg_d;
    logic [4:0]       cnt_q, cnt_d;
    logic             clk500k_q;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             cs_n_q, cs_n_d;
    logic             sclk_q, sclk_d;
    logic             sdo_q, sdo_d;

    logic             rise_tick, fall_tick;
    logic             first_bit, next_bit;
    logic [NBITS-1:0] shreg_adv;

    assign rise_tick = clk500k & ~clk500k_q;
    assign fall_tick = ~clk500k & clk500k_q;

`ifdef BYTE_SHIFTER_LSB_FIRST_EN
    assign first_bit = shreg_q[0];
    assign next_bit  = shreg_q[1];
    assign shreg_adv = shreg_q >> 1;
`else
    assign first_bit = shreg_q[NBITS-1];
    assign next_bit  = shreg_q[NBITS-2];
    assign shreg_adv = shreg_q << 1;
`endif

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        cs_n_d  = cs_n_q;
        sclk_d  = sclk_q;
        sdo_d   = sdo_q;
        case (state_q)
            StIdle: begin
                busy_d = 1'b0;
                cs_n_d = 1'b1;
                sclk_d = 1'b0;
                sdo_d  = 1'b0;
                if (start) begin
                    shreg_d = data;
                    busy_d  = 1'b1;
                    state_d = StSetup;
                end
            end
            StSetup: begin
                if (fall_tick) begin
                    cs_n_d  = 1'b0;
                    sdo_d   = first_bit;
                    cnt_d   = '0;
                    state_d = StShift;
                end
            end
            StShift: begin
                if (rise_tick) begin
                    sclk_d = 1'b1;
                end else if (fall_tick) begin
                    sclk_d = 1'b0;
                    // Done outputs are set on entry so they are registered during the DONE cycle
                    if (cnt_q == LastCnt) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                        cs_n_d  = 1'b1;
                        busy_d  = 1'b0;
                        sdo_d   = 1'b0;
                    end else begin
                        shreg_d = shreg_adv;
                        sdo_d   = next_bit;
                        cnt_d   = cnt_q + 5'd1;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= StIdle;
            shreg_q   <= '0;
            cnt_q     <= '0;
            clk500k_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            sclk_q    <= 1'b0;
            sdo_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            cnt_q     <= cnt_d;
            clk500k_q <= clk500k;
            busy_q    <= busy_d;
            done_q    <= done_d;
            cs_n_q    <= cs_n_d;
            sclk_q    <= sclk_d;
            sdo_q     <= sdo_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign cs_n = cs_n_q;
    assign sclk = sclk_q;
    assign sdo  = sdo_q;

endmodule
